// File: rtl/axi_wr_slave_mem_if.sv
// ---------------------------------------------------------------------------
// axi_wr_slave_mem_if
// AXI3 write-channel bundle (AW, W, B) between a write master and the
// axi_wr_slave_mem responder.
//   master modport : drives AW/W payload + valids and bready,
//                    observes awready/wready/B channel
//   slave  modport : mirror image of master
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (wstrb is DATA_W/8 bits)
// ---------------------------------------------------------------------------
interface axi_wr_slave_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    // write address channel
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    // write data channel
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    // write response channel
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready,
        input  bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready,
        output bid, bresp, bvalid
    );

endinterface

// File: rtl/axi_wr_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_wr_slave_mem
// AXI3 write-channel responder backed by a byte-strobed word memory.
// Accepts one burst at a time (AW -> W beats -> B), writes each beat into
// memory under wstrb, and reports protocol/addressing problems as SLVERR.
// A registered debug port exposes memory contents to a checker.
//
// Ports:
//   aclk      clock
//   arst      synchronous active-high reset (memory contents are kept)
//   bus       axi_wr_slave_mem_if.slave : AW/W inputs, awready/wready/B outputs
//   dbg_idx   debug read word index
//   dbg_data  mem[dbg_idx], registered, 1-cycle latency
//
// Parameters:
//   ADDR_W     address width
//   DATA_W     data width, power of 2, >= 8
//   MEM_DEPTH  memory depth in DATA_W words, power of 2
//
// Build option:
//   AXI_WR_SLV_RANGE_CHK_EN  when defined, beats whose byte address lies
//                            beyond the memory are dropped and flag SLVERR;
//                            otherwise the word index simply wraps.
// ---------------------------------------------------------------------------
module axi_wr_slave_mem #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         aclk,
    input  logic                         arst,
    axi_wr_slave_mem_if.slave            bus,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned SZ_MAX    = $clog2(STRB_W);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * STRB_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // burst context captured at the AW handshake; burst/size already sanitised
    typedef struct packed {
        logic [3:0] id;
        logic [3:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } aw_ctx_t;

    // storage (deliberately not reset)
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // registered state
    state_t            state_q,   state_d;
    aw_ctx_t           ctx_q,     ctx_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [3:0]        beat_q,    beat_d;
    logic              err_q,     err_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [3:0]        bid_q,     bid_d;
    logic [1:0]        bresp_q,   bresp_d;

    // combinational helpers
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              b_hs_c;
    logic [2:0]        aw_size_c;
    logic              aw_size_err_c;
    logic              aw_wrap_len_ok_c;
    logic [1:0]        aw_burst_c;
    logic              aw_err_c;
    logic              last_beat_c;
    logic              oor_c;
    logic              beat_err_c;
    logic [ADDR_W-1:0] incr_c;
    logic [ADDR_W-1:0] wrap_mask_c;
    logic [ADDR_W-1:0] addr_next_c;
    logic [IDX_W-1:0]  widx_c;
    logic              we_c;

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    assign aw_hs_c = bus.awvalid & awready_q;
    assign w_hs_c  = bus.wvalid  & wready_q;
    assign b_hs_c  = bvalid_q    & bus.bready;

    // AW decode: clamp oversize beats, demote reserved/illegal bursts to INCR
    always_comb begin
        aw_size_err_c    = bus.awsize > 3'(SZ_MAX);
        aw_size_c        = aw_size_err_c ? 3'(SZ_MAX) : bus.awsize;
        aw_wrap_len_ok_c = (bus.awlen == 4'd1) || (bus.awlen == 4'd3) ||
                           (bus.awlen == 4'd7) || (bus.awlen == 4'd15);
        aw_burst_c       = bus.awburst;
        if (bus.awburst == BURST_RSVD) begin
            aw_burst_c = BURST_INCR;
        end else if ((bus.awburst == BURST_WRAP) && !aw_wrap_len_ok_c) begin
            aw_burst_c = BURST_INCR;
        end
        aw_err_c = (bus.awburst == BURST_RSVD) || aw_size_err_c ||
                   ((bus.awburst == BURST_WRAP) && !aw_wrap_len_ok_c);
    end

    // out-of-range beat detection
`ifdef AXI_WR_SLV_RANGE_CHK_EN
    assign oor_c = addr_q >= ADDR_W'(MEM_BYTES);
`else
    assign oor_c = 1'b0;
`endif

    // per-beat checks and next beat address
    always_comb begin
        last_beat_c = beat_q == ctx_q.len;
        beat_err_c  = (bus.wlast != last_beat_c) || (bus.wid != ctx_q.id) || oor_c;
        incr_c      = ADDR_W'(1) << ctx_q.size;
        // wrap block size is (len+1) beats; mask selects the in-block offset
        wrap_mask_c = ((ADDR_W'(ctx_q.len) + ADDR_W'(1)) << ctx_q.size) - ADDR_W'(1);
        case (ctx_q.burst)
            BURST_FIXED: addr_next_c = addr_q;
            BURST_WRAP:  addr_next_c = (addr_q & ~wrap_mask_c) |
                                       ((addr_q + incr_c) & wrap_mask_c);
            default:     addr_next_c = addr_q + incr_c;
        endcase
        widx_c = addr_q[SZ_MAX +: IDX_W];
        we_c   = w_hs_c && !oor_c;
    end

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (aw_hs_c) begin
                    ctx_d.id    = bus.awid;
                    ctx_d.len   = bus.awlen;
                    ctx_d.size  = aw_size_c;
                    ctx_d.burst = aw_burst_c;
                    addr_d      = bus.awaddr;
                    beat_d      = 4'd0;
                    err_d       = aw_err_c;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs_c) begin
                    addr_d = addr_next_c;
                    beat_d = beat_q + 4'd1;
                    err_d  = err_q | beat_err_c;
                    // burst length is set by awlen alone; wlast is only checked
                    if (last_beat_c) begin
                        bid_d   = ctx_q.id;
                        bresp_d = (err_q | beat_err_c) ? RESP_SLVERR : RESP_OKAY;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (b_hs_c) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        awready_d = state_d == S_IDLE;
        wready_d  = state_d == S_DATA;
        bvalid_d  = state_d == S_RESP;
    end

    // state and output registers
    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q   <= S_IDLE;
            ctx_q     <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            dbg_data  <= '0;
        end else begin
            state_q   <= state_d;
            ctx_q     <= ctx_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            // reads the pre-edge contents, so same-cycle writes show next cycle
            dbg_data  <= mem[dbg_idx];
        end
    end

    // byte-lane memory write; a beat landing on a reset edge is discarded
    always_ff @(posedge aclk) begin
        if (!arst && we_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (bus.wstrb[i]) begin
                    mem[widx_c][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
module tb_axi_wr_slave_mem;

`ifdef AXI_WR_SLV_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        arst;
    logic [7:0]  dbg_idx;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axi_wr_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_wr_slave_mem #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_DEPTH(256)
    ) dut (
        .aclk    (aclk),
        .arst    (arst),
        .bus     (bus),
        .dbg_idx (dbg_idx),
        .dbg_data(dbg_data)
    );

    typedef struct packed {
        logic [3:0]       id;
        logic [3:0]       wid_x;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       strb;
        logic [31:0]      dbase;
        logic [3:0]       wl_beat;
        logic [1:0]       bresp;
        logic [2:0]       n_chk;
        logic [3:0][7:0]  cidx;
        logic [3:0][31:0] cval;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] id, input logic [3:0] wid_x,
                                input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] strb, input logic [31:0] dbase,
                                input logic [3:0] wl_beat, input logic [1:0] bresp,
                                input logic [2:0] n_chk, input logic [3:0][7:0] cidx,
                                input logic [3:0][31:0] cval);
        vec_t v;
        v.id = id; v.wid_x = wid_x; v.addr = addr; v.len = len; v.size = size;
        v.burst = burst; v.strb = strb; v.dbase = dbase; v.wl_beat = wl_beat;
        v.bresp = bresp; v.n_chk = n_chk; v.cidx = cidx; v.cval = cval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic rd(input logic [7:0] idx, output logic [31:0] d);
        dbg_idx = idx;
        tick();
        d = dbg_data;
    endtask

    task automatic wait_awready(input string name);
        int t = 0;
        while (!bus.awready && t < 50) begin tick(); t++; end
        if (!bus.awready) timeout(name);
    endtask

    task automatic wait_wready(input string name);
        int t = 0;
        while (!bus.wready && t < 50) begin tick(); t++; end
        if (!bus.wready) timeout(name);
    endtask

    task automatic wait_bvalid(input string name);
        int t = 0;
        while (!bus.bvalid && t < 50) begin tick(); t++; end
        if (!bus.bvalid) timeout(name);
    endtask

    // one complete AW / W / B transaction; returns sampled B fields
    task automatic run_burst(input vec_t v, output logic [3:0] rbid, output logic [1:0] rbresp);
        bus.awid = v.id; bus.awaddr = v.addr; bus.awlen = v.len;
        bus.awsize = v.size; bus.awburst = v.burst; bus.awvalid = 1'b1;
        wait_awready("aw_wait");
        tick();
        bus.awvalid = 1'b0;
        for (int k = 0; k <= int'(v.len); k++) begin
            bus.wid    = v.id ^ v.wid_x;
            bus.wdata  = v.dbase + 32'(k);
            bus.wstrb  = v.strb;
            bus.wlast  = (4'(k) == v.wl_beat);
            bus.wvalid = 1'b1;
            wait_wready("w_wait");
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.bready = 1'b1;
        wait_bvalid("b_wait");
        rbid   = bus.bid;
        rbresp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rbid;
        logic [1:0]  rbresp;
        logic [31:0] d;

        // vectors: {id, wid_xor, addr, len, size, burst, strb, data_base, wlast_beat,
        //           bresp, n_checks, word idx[3:0], word val[3:0]}
        vecs[0]  = mk(4'd3, 4'd0, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, 32'd1, 4'd3, 2'b00, 3'd4,
                      {8'd7, 8'd6, 8'd5, 8'd4}, {32'd4, 32'd3, 32'd2, 32'd1});
        vecs[1]  = mk(4'd5, 4'd0, 32'h38, 4'd3, 3'd2, 2'b10, 4'hF, 32'h11, 4'd3, 2'b00, 3'd4,
                      {8'd13, 8'd12, 8'd15, 8'd14}, {32'h14, 32'h13, 32'h12, 32'h11});
        vecs[2]  = mk(4'd7, 4'd0, 32'h10, 4'd3, 3'd2, 2'b01, 4'b0011, 32'hAABBCC00, 4'd2, 2'b10, 3'd4,
                      {8'd7, 8'd6, 8'd5, 8'd4}, {32'hCC03, 32'hCC02, 32'hCC01, 32'hCC00});
        vecs[3]  = mk(4'd1, 4'd0, 32'h20, 4'd3, 3'd2, 2'b00, 4'hF, 32'h21, 4'd3, 2'b00, 3'd1,
                      {8'd0, 8'd0, 8'd0, 8'd8}, {32'd0, 32'd0, 32'd0, 32'h24});
        vecs[4]  = mk(4'd2, 4'h8, 32'h40, 4'd0, 3'd2, 2'b01, 4'hF, 32'h41, 4'd0, 2'b10, 3'd1,
                      {8'd0, 8'd0, 8'd0, 8'd16}, {32'd0, 32'd0, 32'd0, 32'h41});
        vecs[5]  = mk(4'd4, 4'd0, 32'h50, 4'd1, 3'd2, 2'b11, 4'hF, 32'h51, 4'd1, 2'b10, 3'd2,
                      {8'd0, 8'd0, 8'd21, 8'd20}, {32'd0, 32'd0, 32'h52, 32'h51});
        vecs[6]  = mk(4'd6, 4'd0, 32'h60, 4'd1, 3'd3, 2'b01, 4'hF, 32'h61, 4'd1, 2'b10, 3'd2,
                      {8'd0, 8'd0, 8'd25, 8'd24}, {32'd0, 32'd0, 32'h62, 32'h61});
        vecs[7]  = mk(4'd9, 4'd0, 32'h70, 4'd2, 3'd2, 2'b10, 4'hF, 32'h71, 4'd2, 2'b10, 3'd3,
                      {8'd0, 8'd30, 8'd29, 8'd28}, {32'd0, 32'h73, 32'h72, 32'h71});
        vecs[8]  = mk(4'd10, 4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 4'hF, 32'hDEAD0000, 4'd0, 2'b00, 3'd1,
                      {8'd0, 8'd0, 8'd0, 8'd0}, {32'd0, 32'd0, 32'd0, 32'hDEAD0000});
        vecs[9]  = mk(4'd11, 4'd0, 32'h400, 4'd0, 3'd2, 2'b01, 4'hF, 32'h0BAD0400, 4'd0,
                      RC ? 2'b10 : 2'b00, 3'd1, {8'd0, 8'd0, 8'd0, 8'd0},
                      {32'd0, 32'd0, 32'd0, RC ? 32'hDEAD0000 : 32'h0BAD0400});
        vecs[10] = mk(4'd12, 4'd0, 32'h80, 4'd3, 3'd1, 2'b01, 4'hF, 32'h81, 4'd3, 2'b00, 3'd2,
                      {8'd0, 8'd0, 8'd33, 8'd32}, {32'd0, 32'd0, 32'h84, 32'h82});
        vecs[11] = mk(4'd13, 4'd0, 32'h94, 4'd1, 3'd2, 2'b10, 4'hF, 32'h91, 4'd1, 2'b00, 3'd2,
                      {8'd0, 8'd0, 8'd36, 8'd37}, {32'd0, 32'd0, 32'h92, 32'h91});

        arst = 1'b1;
        dbg_idx = 8'd0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        // reset values
        repeat (3) tick();
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_bid", 32'(bus.bid), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        chk("rst_dbg", dbg_data, 32'd0);
        arst = 1'b0;
        chk("rel_awready_same", 32'(bus.awready), 32'd0);
        tick();
        chk("rel_awready_next", 32'(bus.awready), 32'd1);
        chk("rel_bvalid", 32'(bus.bvalid), 32'd0);

        // table-driven bursts
        for (int i = 0; i < NVEC; i++) begin
            run_burst(vecs[i], rbid, rbresp);
            chk($sformatf("v%0d_bid", i), 32'(rbid), 32'(vecs[i].id));
            chk($sformatf("v%0d_bresp", i), 32'(rbresp), 32'(vecs[i].bresp));
            for (int j = 0; j < int'(vecs[i].n_chk); j++) begin
                rd(vecs[i].cidx[j], d);
                chk($sformatf("v%0d_mem[%0d]", i, vecs[i].cidx[j]), d, vecs[i].cval[j]);
            end
        end

        // back-pressured B, AW held off, latencies and read-before-write
        dbg_idx = 8'd4;
        bus.awid = 4'hE; bus.awaddr = 32'h10; bus.awlen = 4'd1; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        wait_awready("seq_aw_wait");
        tick();
        chk("seq_wready_after_aw", 32'(bus.wready), 32'd1);
        chk("seq_awready_after_aw", 32'(bus.awready), 32'd0);
        bus.wid = 4'hE; bus.wdata = 32'h5A0; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        tick();
        chk("seq_dbg_old", dbg_data, 32'hCC00);
        bus.wdata = 32'h5A1; bus.wlast = 1'b1;
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("seq_dbg_new", dbg_data, 32'h5A0);
        chk("seq_wready_end", 32'(bus.wready), 32'd0);
        chk("seq_bvalid_up", 32'(bus.bvalid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("hold%0d_bvalid", c), 32'(bus.bvalid), 32'd1);
            chk($sformatf("hold%0d_bid", c), 32'(bus.bid), 32'hE);
            chk($sformatf("hold%0d_bresp", c), 32'(bus.bresp), 32'd0);
            chk($sformatf("hold%0d_awready", c), 32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.awvalid = 1'b0;
        chk("seq_bvalid_down", 32'(bus.bvalid), 32'd0);
        chk("seq_awready_back", 32'(bus.awready), 32'd1);
        tick();
        chk("seq_no_stray_aw", 32'(bus.wready), 32'd0);
        rd(8'd5, d);
        chk("seq_mem5", d, 32'h5A1);

        // reset in the middle of a burst
        bus.awid = 4'h1; bus.awaddr = 32'hC0; bus.awlen = 4'd3; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        wait_awready("abort_aw_wait");
        tick();
        bus.awvalid = 1'b0;
        bus.wid = 4'h1; bus.wdata = 32'h777; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        arst = 1'b1;
        tick();
        chk("abort_awready", 32'(bus.awready), 32'd0);
        chk("abort_wready", 32'(bus.wready), 32'd0);
        chk("abort_bvalid", 32'(bus.bvalid), 32'd0);
        chk("abort_dbg", dbg_data, 32'd0);
        arst = 1'b0;
        tick();
        chk("abort_awready_back", 32'(bus.awready), 32'd1);
        repeat (3) tick();
        chk("abort_no_b", 32'(bus.bvalid), 32'd0);
        rd(8'd48, d);
        chk("abort_partial_kept", d, 32'h777);
        run_burst(vecs[0], rbid, rbresp);
        chk("recover_bresp", 32'(rbresp), 32'd0);
        chk("recover_bid", 32'(rbid), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
